mnist_mlp_weight_loader: RTL and testbench

Streaming parameter loader that sits directly upstream of the `mnist_mlp` accelerator's weight/bias memories. It accepts one fixed-point word per beat over a valid/ready stream and steers each word onto a single registered write port: segment, bank, address, data. Segments are W2, B2, W4, B4, W6 and B6. External decode uses this port to fill the `w2_rsc_*_0`, `b2_rsc`, `w4_rsc_*_0`, `b4_rsc`, `w6_rsc_*_0` and `b6_rsc` stores before inference starts.

---
 rtl/mnist_mlp_weight_loader.sv | 172 +++++++++++++++++
 tb/tb_mnist_mlp_weight_loader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mnist_mlp_weight_loader.sv
// mnist_mlp_weight_loader: streams fixed-point parameter words into the
// W2/B2/W4/B4/W6/B6 stores through one registered write port.
//
// Handshake: a beat transfers on a rising edge where in_vld && in_rdy.
// in_rdy is combinational: high only in LOAD while abort is low. The loader
// never back-pressures on its own, so throughput is one beat per cycle.
module mnist_mlp_weight_loader #(
  parameter int W_BITS  = 18,
  parameter int IN_DIM  = 784,
  parameter int H1      = 64,
  parameter int H2      = 64,
  parameter int OUT_DIM = 10,
  parameter int BANK_W  = $clog2((((H1 > H2) ? H1 : H2) > OUT_DIM) ? ((H1 > H2) ? H1 : H2) : OUT_DIM),
  parameter int ADDR_W  = $clog2((((IN_DIM > H1) ? IN_DIM : H1) > H2) ? ((IN_DIM > H1) ? IN_DIM : H1) : H2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [W_BITS-1:0] in_dat,
  input  logic              in_vld,
  output logic              in_rdy,
  output logic              wr_en,
  output logic [2:0]        wr_seg,
  output logic [BANK_W-1:0] wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [W_BITS-1:0] wr_dat,
  output logic              busy,
  output logic              done,
  output logic [15:0]       beat_cnt,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [2:0] SEG_W2 = 3'd0;
  localparam logic [2:0] SEG_B2 = 3'd1;
  localparam logic [2:0] SEG_W4 = 3'd2;
  localparam logic [2:0] SEG_B4 = 3'd3;
  localparam logic [2:0] SEG_W6 = 3'd4;
  localparam logic [2:0] SEG_B6 = 3'd5;

  localparam logic [ADDR_W-1:0] DEP_IN_M1  = ADDR_W'(IN_DIM - 1);
  localparam logic [ADDR_W-1:0] DEP_H1_M1  = ADDR_W'(H1 - 1);
  localparam logic [ADDR_W-1:0] DEP_H2_M1  = ADDR_W'(H2 - 1);
  localparam logic [ADDR_W-1:0] DEP_OUT_M1 = ADDR_W'(OUT_DIM - 1);
  localparam logic [BANK_W-1:0] BNK_H1_M1  = BANK_W'(H1 - 1);
  localparam logic [BANK_W-1:0] BNK_H2_M1  = BANK_W'(H2 - 1);
  localparam logic [BANK_W-1:0] BNK_OUT_M1 = BANK_W'(OUT_DIM - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_seg;
  logic [BANK_W-1:0]   r_bank;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_beat_cnt;
  logic                r_wr_en;
  logic [2:0]          r_wr_seg;
  logic [BANK_W-1:0]   r_wr_bank;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [W_BITS-1:0]   r_wr_dat;

  logic [ADDR_W-1:0]   w_depth_m1;
  logic [BANK_W-1:0]   w_banks_m1;
  logic                w_addr_wrap;
  logic                w_bank_wrap;
  logic                w_last;
  logic                w_accept;

  // Geometry of the segment currently being filled (bias segments have one bank).
  always_comb begin
    w_depth_m1 = DEP_OUT_M1;
    w_banks_m1 = '0;
    case (r_seg)
      SEG_W2: begin w_depth_m1 = DEP_IN_M1; w_banks_m1 = BNK_H1_M1;  end
      SEG_B2: begin w_depth_m1 = DEP_H1_M1; w_banks_m1 = '0;         end
      SEG_W4: begin w_depth_m1 = DEP_H1_M1; w_banks_m1 = BNK_H2_M1;  end
      SEG_B4: begin w_depth_m1 = DEP_H2_M1; w_banks_m1 = '0;         end
      SEG_W6: begin w_depth_m1 = DEP_H2_M1; w_banks_m1 = BNK_OUT_M1; end
      SEG_B6: begin w_depth_m1 = DEP_OUT_M1; w_banks_m1 = '0;        end
      default: begin w_depth_m1 = DEP_OUT_M1; w_banks_m1 = '0;       end
    endcase
  end

  assign in_rdy      = (r_state == S_LOAD) && !abort;
  assign w_accept    = in_vld && in_rdy;
  assign w_addr_wrap = (r_addr == w_depth_m1);
  assign w_bank_wrap = (r_bank == w_banks_m1);
  assign w_last      = (r_seg == SEG_B6) && w_addr_wrap;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state: abort wins over completion; FIN lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (abort)                    w_state_nxt = S_IDLE;
        else if (w_accept && w_last)  w_state_nxt = S_FIN;
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Position counters: cleared on start, advanced bank-major on each beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seg      <= '0;
      r_bank     <= '0;
      r_addr     <= '0;
      r_beat_cnt <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_seg      <= '0;
      r_bank     <= '0;
      r_addr     <= '0;
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      if (r_beat_cnt != 16'hFFFF) r_beat_cnt <= r_beat_cnt + 16'd1;
      if (w_addr_wrap) begin
        r_addr <= '0;
        if (w_bank_wrap) begin
          r_bank <= '0;
          r_seg  <= r_seg + 3'd1;
        end else begin
          r_bank <= r_bank + 1'b1;
        end
      end else begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  // Registered write port: one write per accepted beat, one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_en   <= 1'b0;
      r_wr_seg  <= '0;
      r_wr_bank <= '0;
      r_wr_addr <= '0;
      r_wr_dat  <= '0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_wr_seg  <= r_seg;
        r_wr_bank <= r_bank;
        r_wr_addr <= r_addr;
        r_wr_dat  <= in_dat;
      end
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_seg    = r_wr_seg;
  assign wr_bank   = r_wr_bank;
  assign wr_addr   = r_wr_addr;
  assign wr_dat    = r_wr_dat;
  assign busy      = (r_state == S_LOAD);
  assign done      = (r_state == S_FIN);
  assign beat_cnt  = r_beat_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mnist_mlp_weight_loader.sv
// tb_mnist_mlp_weight_loader: directed bench for the parameter loader.
// u_big uses the default geometry; u_small uses a reduced one so that the
// stalled-stream, abort-restart and ignored-start cases stay short.
module tb_mnist_mlp_weight_loader;

  localparam int REC_W = 41;  // {seg[2:0], bank[7:0], addr[11:0], dat[17:0]}
  localparam int TOTAL_BIG = 55050;
  localparam int S_IN = 12, S_H1 = 4, S_H2 = 3, S_OUT = 2;
  localparam int TOTAL_SMALL = S_H1*S_IN + S_H1 + S_H2*S_H1 + S_H2 + S_OUT*S_H2 + S_OUT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic b_rst = 1'b0, s_rst = 1'b0;

  // ---------------- DUT signals ----------------
  logic        b_start = 0, b_abort = 0, b_in_vld = 0;
  logic [17:0] b_in_dat = '0;
  logic        b_in_rdy, b_wr_en, b_busy, b_done;
  logic [2:0]  b_wr_seg;
  logic [5:0]  b_wr_bank;
  logic [9:0]  b_wr_addr;
  logic [17:0] b_wr_dat;
  logic [15:0] b_beat_cnt;
  logic [1:0]  b_dbg_state;

  logic        s_start = 0, s_abort = 0, s_in_vld = 0;
  logic [17:0] s_in_dat = '0;
  logic        s_in_rdy, s_wr_en, s_busy, s_done;
  logic [2:0]  s_wr_seg;
  logic [1:0]  s_wr_bank;
  logic [3:0]  s_wr_addr;
  logic [17:0] s_wr_dat;
  logic [15:0] s_beat_cnt;
  logic [1:0]  s_dbg_state;

  mnist_mlp_weight_loader u_big (
    .clk(clk), .rst(b_rst), .start(b_start), .abort(b_abort),
    .in_dat(b_in_dat), .in_vld(b_in_vld), .in_rdy(b_in_rdy),
    .wr_en(b_wr_en), .wr_seg(b_wr_seg), .wr_bank(b_wr_bank),
    .wr_addr(b_wr_addr), .wr_dat(b_wr_dat), .busy(b_busy), .done(b_done),
    .beat_cnt(b_beat_cnt), .dbg_state(b_dbg_state)
  );

  mnist_mlp_weight_loader #(
    .W_BITS(18), .IN_DIM(S_IN), .H1(S_H1), .H2(S_H2), .OUT_DIM(S_OUT)
  ) u_small (
    .clk(clk), .rst(s_rst), .start(s_start), .abort(s_abort),
    .in_dat(s_in_dat), .in_vld(s_in_vld), .in_rdy(s_in_rdy),
    .wr_en(s_wr_en), .wr_seg(s_wr_seg), .wr_bank(s_wr_bank),
    .wr_addr(s_wr_addr), .wr_dat(s_wr_dat), .busy(s_busy), .done(s_done),
    .beat_cnt(s_beat_cnt), .dbg_state(s_dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] s_exp_q[$];
  int n_cmp = 0, n_err = 0;
  int n_wr_b = 0, n_wr_s = 0, n_done_b = 0, n_done_s = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Big-instance monitor: every write must match the oldest expected beat.
  always @(negedge clk) begin
    logic [REC_W-1:0] got, e;
    if (b_done) n_done_b++;
    if (b_rst && b_wr_en) begin
      n_wr_b++;
      got = {b_wr_seg, 8'(b_wr_bank), 12'(b_wr_addr), b_wr_dat};
      if (exp_q.size() == 0) chk("big_unexpected_wr", 64'(got), 64'h0);
      else begin
        e = exp_q.pop_front();
        chk($sformatf("big_wr_beat%0d", e[17:0]), 64'(got), 64'(e));
      end
    end
  end

  // Small-instance monitor.
  always @(negedge clk) begin
    logic [REC_W-1:0] got, e;
    if (s_done) n_done_s++;
    if (s_rst && s_wr_en) begin
      n_wr_s++;
      got = {s_wr_seg, 8'(s_wr_bank), 12'(s_wr_addr), s_wr_dat};
      if (s_exp_q.size() == 0) chk("small_unexpected_wr", 64'(got), 64'h0);
      else begin
        e = s_exp_q.pop_front();
        chk($sformatf("small_wr_beat%0d", e[17:0]), 64'(got), 64'(e));
      end
    end
  end

  // ---------------- stimulus model ----------------
  int g_seg, g_bank, g_addr, g_idx;

  function automatic int seg_banks(input bit sel, input int seg);
    case (seg)
      0: return sel ? S_H1  : 64;
      2: return sel ? S_H2  : 64;
      4: return sel ? S_OUT : 10;
      default: return 1;
    endcase
  endfunction

  function automatic int seg_depth(input bit sel, input int seg);
    case (seg)
      0: return sel ? S_IN : 784;
      1: return sel ? S_H1 : 64;
      2: return sel ? S_H1 : 64;
      3: return sel ? S_H2 : 64;
      4: return sel ? S_H2 : 64;
      default: return sel ? S_OUT : 10;
    endcase
  endfunction

  // Drive n beats; each accepted beat pushes its expected write record.
  task automatic drive_beats(input bit sel, input int n, input int vld_pct);
    int tries;
    bit v, acc;
    logic [REC_W-1:0] rec;
    for (int k = 0; k < n; k++) begin
      acc = 0;
      tries = 0;
      while (!acc) begin
        @(negedge clk);
        v = ($urandom_range(99) < vld_pct);
        if (sel) begin s_in_vld = v; s_in_dat = g_idx[17:0]; end
        else     begin b_in_vld = v; b_in_dat = g_idx[17:0]; end
        #1;
        acc = v && (sel ? s_in_rdy : b_in_rdy);
        if (acc) begin
          rec = {3'(g_seg), 8'(g_bank), 12'(g_addr), g_idx[17:0]};
          if (sel) s_exp_q.push_back(rec); else exp_q.push_back(rec);
          g_idx++;
          g_addr++;
          if (g_addr == seg_depth(sel, g_seg)) begin
            g_addr = 0;
            g_bank++;
            if (g_bank == seg_banks(sel, g_seg)) begin
              g_bank = 0;
              g_seg++;
            end
          end
        end else begin
          tries++;
          if (tries > 200) begin
            n_err++;
            $display("FAIL drive_timeout observed=in_rdy_low expected=accept beat=%0d", g_idx);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $fatal(1, "beat never accepted");
          end
        end
      end
    end
  endtask

  task automatic pulse_start(input bit sel);
    g_seg = 0; g_bank = 0; g_addr = 0; g_idx = 0;
    @(negedge clk);
    if (sel) s_start = 1; else b_start = 1;
    @(negedge clk);
    if (sel) s_start = 0; else b_start = 0;
    #1;
    chk("start_busy",  64'(sel ? s_busy : b_busy), 64'd1);
    chk("start_rdy",   64'(sel ? s_in_rdy : b_in_rdy), 64'd1);
    chk("start_clear", 64'(sel ? s_beat_cnt : b_beat_cnt), 64'd0);
  endtask

  task automatic chk_big_reset_values(input string pfx);
    chk({pfx, "_in_rdy"},   64'(b_in_rdy), 64'd0);
    chk({pfx, "_wr_en"},    64'(b_wr_en), 64'd0);
    chk({pfx, "_busy"},     64'(b_busy), 64'd0);
    chk({pfx, "_done"},     64'(b_done), 64'd0);
    chk({pfx, "_wr_seg"},   64'(b_wr_seg), 64'd0);
    chk({pfx, "_wr_bank"},  64'(b_wr_bank), 64'd0);
    chk({pfx, "_wr_addr"},  64'(b_wr_addr), 64'd0);
    chk({pfx, "_wr_dat"},   64'(b_wr_dat), 64'd0);
    chk({pfx, "_beat_cnt"}, 64'(b_beat_cnt), 64'd0);
    chk({pfx, "_state"},    64'(b_dbg_state), 64'd0);
  endtask

  // Watchdog bounds the whole run.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int wr0, dn0;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk_big_reset_values("rst");
    chk("rst_small_busy", 64'(s_busy), 64'd0);
    b_rst = 1; s_rst = 1;

    // Abort after 1000 beats on the default geometry.
    pulse_start(0);
    drive_beats(0, 1000, 100);
    @(negedge clk);
    b_abort = 1; b_in_vld = 1;
    #1;
    chk("abort_in_rdy", 64'(b_in_rdy), 64'd0);
    @(negedge clk);
    b_abort = 0; b_in_vld = 0;
    #1;
    chk("abort_busy",     64'(b_busy), 64'd0);
    chk("abort_done",     64'(b_done), 64'd0);
    chk("abort_no_wr",    64'(b_wr_en), 64'd0);
    chk("abort_beat_cnt", 64'(b_beat_cnt), 64'd1000);
    chk("abort_writes",   64'(n_wr_b), 64'd1000);
    repeat (3) @(negedge clk);
    #1;
    chk("abort_q_empty",  64'(exp_q.size()), 64'd0);
    chk("abort_no_done",  64'(n_done_b), 64'd0);

    // Async reset in the middle of W2.
    pulse_start(0);
    drive_beats(0, 500, 100);
    @(negedge clk);
    b_in_vld = 0;
    #2;
    b_rst = 0;
    #1;
    chk_big_reset_values("arst");
    repeat (2) @(negedge clk);
    #1;
    chk("arst_hold_busy", 64'(b_busy), 64'd0);
    chk("arst_hold_wr",   64'(b_wr_en), 64'd0);
    exp_q.delete();
    b_rst = 1;

    // Full back-to-back load with an ignored start pulse inside.
    pulse_start(0);
    wr0 = n_wr_b; dn0 = n_done_b;
    drive_beats(0, 30000, 100);
    b_start = 1;
    drive_beats(0, 1, 100);
    b_start = 0;
    drive_beats(0, TOTAL_BIG - 30001, 100);
    @(negedge clk);
    b_in_vld = 0;
    #1;
    chk("full_done",     64'(b_done), 64'd1);
    chk("full_busy",     64'(b_busy), 64'd0);
    chk("full_rdy",      64'(b_in_rdy), 64'd0);
    chk("full_state",    64'(b_dbg_state), 64'd2);
    chk("full_beat_cnt", 64'(b_beat_cnt), 64'(TOTAL_BIG));
    @(negedge clk);
    #1;
    chk("full_done_pulse", 64'(b_done), 64'd0);
    chk("full_cnt_hold",   64'(b_beat_cnt), 64'(TOTAL_BIG));
    chk("full_writes",     64'(n_wr_b - wr0), 64'(TOTAL_BIG));
    chk("full_done_once",  64'(n_done_b - dn0), 64'd1);
    chk("full_q_empty",    64'(exp_q.size()), 64'd0);

    // Small geometry: stalled stream, abort, then restart from zero.
    pulse_start(1);
    drive_beats(1, 20, 50);
    @(negedge clk);
    s_abort = 1; s_in_vld = 1;
    #1;
    chk("s_abort_in_rdy", 64'(s_in_rdy), 64'd0);
    @(negedge clk);
    s_abort = 0; s_in_vld = 0;
    #1;
    chk("s_abort_busy", 64'(s_busy), 64'd0);
    chk("s_abort_done", 64'(n_done_s), 64'd0);
    chk("s_abort_cnt",  64'(s_beat_cnt), 64'd20);

    pulse_start(1);
    wr0 = n_wr_s;
    drive_beats(1, 40, 50);
    s_start = 1;
    drive_beats(1, 1, 50);
    s_start = 0;
    drive_beats(1, TOTAL_SMALL - 41, 50);
    @(negedge clk);
    s_in_vld = 0;
    #1;
    chk("s_full_done",     64'(s_done), 64'd1);
    chk("s_full_busy",     64'(s_busy), 64'd0);
    chk("s_full_beat_cnt", 64'(s_beat_cnt), 64'(TOTAL_SMALL));
    chk("s_full_writes",   64'(n_wr_s - wr0), 64'(TOTAL_SMALL));
    @(negedge clk);
    #1;
    chk("s_done_pulse",    64'(s_done), 64'd0);
    chk("s_done_once",     64'(n_done_s), 64'd1);
    chk("s_q_empty",       64'(s_exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
